alu_issue: RTL and testbench

Issue and writeback controller on the driving side of the ALU. Accepts one RV32I instruction at a time over a valid/ready handshake, decodes ADD and ADDI, and reads source operands from an internal 32×32 register file. It drives `op1`/`op2`/`is_add`/`is_addi` into the ALU, captures `result`, and writes it back to `rd`. It sits between instruction fetch and the combinational ALU in the Chapter 4 core.

---
 rtl/alu_issue_pkg.sv | 23 ++
 rtl/alu_issue_regfile.sv | 35 +++
 rtl/alu_issue.sv | 121 ++++++++++++
 tb/tb_alu_issue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - decode constants, FSM states and immediate helper for alu_issue
// Optional TRAP state is present only when ALU_ISSUE_TRAP_EN is defined.
package alu_issue_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
`ifdef ALU_ISSUE_TRAP_EN
    , S_TRAP = 2'd3
`endif
  } issue_state_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - 32x32 register file, two read ports plus debug read, one write port
// x0 reads as zero and is never written; whole array clears on reset.
module alu_issue_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [XLEN-1:0] o_dbg_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - serial ADD/ADDI issue and writeback controller driving a combinational ALU
// ALU_ISSUE_TRAP_EN: unsupported instructions lock into TRAP instead of retiring as NOPs.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            is_add,
  output logic            is_addi,
  input  logic [XLEN-1:0] result,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
`ifdef ALU_ISSUE_TRAP_EN
  , output logic          illegal
`endif
);

  issue_state_t    r_state, w_state_next;
  logic [XLEN-1:0] r_op1, r_op2, r_cap;
  logic            r_is_add, r_is_addi;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic            w_is_add, w_is_addi, w_legal, w_fire;

  assign w_is_add  = (instr[6:0] == OP) && (instr[14:12] == F3_ADD) && (instr[31:25] == F7_ADD);
  assign w_is_addi = (instr[6:0] == OP_IMM) && (instr[14:12] == F3_ADD);
  assign w_legal   = w_is_add | w_is_addi;
  assign w_fire    = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
`ifdef ALU_ISSUE_TRAP_EN
          w_state_next = w_legal ? S_ISSUE : S_TRAP;
`else
          w_state_next = S_ISSUE;
`endif
        end
      end
      S_ISSUE: w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
`ifdef ALU_ISSUE_TRAP_EN
      S_TRAP:  w_state_next = S_TRAP;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Unsupported words load zeros and rd=0 so they flow through as a NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_is_add  <= 1'b0;
      r_is_addi <= 1'b0;
      r_rd      <= '0;
      r_cap     <= '0;
    end else begin
      if (w_fire) begin
        r_op1     <= w_legal ? w_rs1_data : '0;
        r_op2     <= w_is_add ? w_rs2_data : (w_is_addi ? imm_i(instr) : '0);
        r_is_add  <= w_is_add;
        r_is_addi <= w_is_addi;
        r_rd      <= w_legal ? instr[11:7] : 5'd0;
      end
      if (r_state == S_ISSUE) r_cap <= result;
      if (r_state == S_WB) begin
        r_op1     <= '0;
        r_op2     <= '0;
        r_is_add  <= 1'b0;
        r_is_addi <= 1'b0;
        r_rd      <= '0;
      end
    end
  end

  alu_issue_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (instr[19:15]),
    .i_rs2_addr (instr[24:20]),
    .i_dbg_addr (dbg_addr),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .o_dbg_data (dbg_data),
    .i_we       (r_state == S_WB),
    .i_waddr    (r_rd),
    .i_wdata    (r_cap)
  );

  assign instr_ready  = (r_state == S_IDLE);
  assign op1          = r_op1;
  assign op2          = r_op2;
  assign is_add       = r_is_add;
  assign is_addi      = r_is_addi;
  assign retire_valid = (r_state == S_WB);
  assign retire_rd    = (r_state == S_WB) ? r_rd : 5'd0;
  assign retire_data  = ((r_state == S_WB) && (r_rd != 5'd0)) ? r_cap : '0;
`ifdef ALU_ISSUE_TRAP_EN
  assign illegal      = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue with table vectors and random model checks
module tb_alu_issue;

  logic        clk, reset, instr_valid, instr_ready;
  logic [31:0] instr, op1, op2, result, retire_data, dbg_data;
  logic        is_add, is_addi, retire_valid;
  logic [4:0]  retire_rd, dbg_addr;
`ifdef ALU_ISSUE_TRAP_EN
  logic        illegal;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] m [32];

  alu_issue dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .op1(op1), .op2(op2), .is_add(is_add),
    .is_addi(is_addi), .result(result), .retire_valid(retire_valid),
    .retire_rd(retire_rd), .retire_data(retire_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`ifdef ALU_ISSUE_TRAP_EN
    , .illegal(illegal)
`endif
  );

  // ALU stand-in; junk when nothing is selected so NOP retires must not leak it
  assign result = (is_add || is_addi) ? op1 + op2 : 32'hDEADBEEF;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [31:0] val;
  } vec_t;

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_sub(input logic [4:0] rd, rs1, rs2);
    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 8 && !instr_ready; k++) @(negedge clk);
    check("ready_wait", instr_ready, 1);
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check("dbg_read", dbg_data, exp);
  endtask

  // Issue one instruction at a negedge and check every cycle of its 3-cycle life
  task automatic send(input logic [31:0] ins);
    logic        ea, eai;
    logic [4:0]  rd;
    logic [31:0] e1, e2, res;
    ea  = ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'b0000000;
    eai = ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000;
    rd  = (ea || eai) ? ins[11:7] : 5'd0;
    e1  = (ea || eai) ? m[ins[19:15]] : 32'd0;
    e2  = ea ? m[ins[24:20]] : (eai ? int'($signed(ins[31:20])) : 32'd0);
    res = e1 + e2;
    wait_ready();
    instr_valid = 1;
    instr = ins;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    instr = $urandom;
    check("issue_ready", instr_ready, 0);
    check("issue_retire", retire_valid, 0);
    check("issue_op1", op1, e1);
    check("issue_op2", op2, e2);
    check("issue_is_add", is_add, ea);
    check("issue_is_addi", is_addi, eai);
    @(negedge clk);
    check("wb_ready", instr_ready, 0);
    check("wb_retire", retire_valid, 1);
    check("wb_rd", retire_rd, rd);
    check("wb_data", retire_data, (rd == 0) ? 32'd0 : res);
    if (rd != 0) m[rd] = res;
    @(negedge clk);
    check("idle_ready", instr_ready, 1);
    check("idle_retire", retire_valid, 0);
    check("idle_op1", op1, 0);
    check("idle_op2", op2, 0);
    check("idle_sel", {is_add, is_addi}, 0);
    peek(ins[11:7], m[ins[11:7]]);
  endtask

  vec_t vt[5];
  int acc, ret;
  logic [31:0] x6_old;

  initial begin
    vt[0] = '{enc_addi(5'd1, 5'd0, 12'd5),     5'd1, 32'd5};
    vt[1] = '{enc_addi(5'd2, 5'd0, 12'hFFD),   5'd2, 32'hFFFFFFFD};
    vt[2] = '{enc_add(5'd3, 5'd1, 5'd2),       5'd3, 32'd2};
    vt[3] = '{enc_addi(5'd0, 5'd0, 12'd7),     5'd0, 32'd0};
    vt[4] = '{enc_add(5'd5, 5'd1, 5'd1),       5'd5, 32'd10};

    for (int i = 0; i < 32; i++) m[i] = 0;
    reset = 1; instr_valid = 0; instr = 0; dbg_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_sel", {is_add, is_addi}, 0);
    check("rst_retire", retire_valid, 0);
`ifdef ALU_ISSUE_TRAP_EN
    check("rst_illegal", illegal, 0);
`endif
    for (int a = 0; a < 32; a++) peek(5'(a), 32'd0);

    for (int i = 0; i < 5; i++) begin
      send(vt[i].ins);
      peek(vt[i].rd, vt[i].val);
    end

    send(enc_addi(5'd3, 5'd0, 12'd1));
    for (int i = 0; i < 31; i++) send(enc_add(5'd3, 5'd3, 5'd3));
    peek(5'd3, 32'h80000000);
    send(enc_add(5'd4, 5'd3, 5'd3));
    peek(5'd4, 32'd0);

    // valid held high: one acceptance every 3 cycles
    wait_ready();
    x6_old = m[6];
    acc = 0; ret = 0;
    instr_valid = 1;
    instr = enc_addi(5'd6, 5'd6, 12'd1);
    for (int c = 0; c < 30; c++) begin
      if (instr_ready) acc++;
      if (retire_valid) ret++;
      @(negedge clk);
    end
    instr_valid = 0;
    check("stream_accepts", acc, 10);
    check("stream_retires", ret, 10);
    m[6] = x6_old + 10;
    peek(5'd6, m[6]);

    // reset during ISSUE drops the instruction
    wait_ready();
    instr_valid = 1;
    instr = enc_addi(5'd7, 5'd0, 12'd99);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    check("midrst_ready", instr_ready, 1);
    check("midrst_retire", retire_valid, 0);
    @(negedge clk);
    check("midrst_retire2", retire_valid, 0);
    for (int i = 0; i < 32; i++) m[i] = 0;
    peek(5'd7, 32'd0);
    peek(5'd1, 32'd0);

    send(enc_addi(5'd1, 5'd0, 12'd100));
    send(enc_addi(5'd2, 5'd0, 12'h800));
    for (int n = 0; n < 40; n++) begin
      logic [4:0] rd, rs1, rs2;
      int kind;
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
`ifdef ALU_ISSUE_TRAP_EN
      kind = $urandom_range(0, 1);
`else
      kind = $urandom_range(0, 3);
`endif
      case (kind)
        0: send(enc_add(rd, rs1, rs2));
        1: send(enc_addi(rd, rs1, 12'($urandom)));
        2: send(enc_sub(rd, rs1, rs2));
        default: send($urandom);
      endcase
    end

`ifdef ALU_ISSUE_TRAP_EN
    wait_ready();
    instr_valid = 1;
    instr = enc_sub(5'd8, 5'd1, 5'd2);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    for (int c = 0; c < 4; c++) begin
      check("trap_illegal", illegal, 1);
      check("trap_ready", instr_ready, 0);
      check("trap_retire", retire_valid, 0);
      @(negedge clk);
    end
    peek(5'd8, m[8]);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    check("trap_rst_illegal", illegal, 0);
    check("trap_rst_ready", instr_ready, 1);
`else
    send(enc_sub(5'd8, 5'd1, 5'd2));
    peek(5'd8, m[8]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
